// File: rtl/sram_rw_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_rw_arbiter_if
// Purpose : bundles the two requester channels and the 1RW+1R SRAM macro pins
//           served by sram_rw_arbiter.
// Ports   : parameters DATA_WIDTH / ADDR_WIDTH must match the macro.
//   requester A/B : *_req, *_we, *_addr, *_wdata (to arbiter)
//                   *_gnt (comb), *_rvalid, *_rdata (registered, from arbiter)
//   macro port 0  : csb0, web0, addr0, din0 (from arbiter), dout0 (to arbiter)
//   macro port 1  : csb1, addr1 (from arbiter), dout1 (to arbiter)
// Modports: slave = arbiter side, master = requester/macro side.
// ---------------------------------------------------------------------------
interface sram_rw_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
);
   // requester A
   logic                  a_req;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_gnt;
   logic                  a_rvalid;
   logic [DATA_WIDTH-1:0] a_rdata;
   // requester B
   logic                  b_req;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_gnt;
   logic                  b_rvalid;
   logic [DATA_WIDTH-1:0] b_rdata;
   // macro port 0 (RW)
   logic                  csb0;
   logic                  web0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;
   // macro port 1 (R)
   logic                  csb1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] dout1;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata,
      output csb0, web0, addr0, din0,
      input  dout0,
      output csb1, addr1,
      input  dout1
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  csb0, web0, addr0, din0,
      output dout0,
      input  csb1, addr1,
      output dout1
   );
endinterface

// File: rtl/sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rw_arbiter
// Purpose : shares a 1RW+1R SRAM macro between requesters A and B. The
//           round-robin winner takes port 0 (read or write); the other
//           requester's read rides on port 1 in the same cycle when it does
//           not collide with a same-address write. Reads return two cycles
//           after grant, tagged back to the issuing requester.
// Ports   :
//   clk    in  single clock (macro clk0/clk1 are driven from the same net)
//   rst_n  in  asynchronous active-low reset
//   bus    sram_rw_arbiter_if.slave: requester handshakes + macro pins
// ---------------------------------------------------------------------------
module sram_rw_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sram_rw_arbiter_if.slave     bus
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned AW = ADDR_WIDTH;

   // prio: 0 = A preferred, 1 = B preferred
   logic          prio_q, prio_d;
   // per-port read tag stage 1: valid + owner (0 = A, 1 = B)
   logic          p0_v_q, p0_v_d, p0_own_q, p0_own_d;
   logic          p1_v_q, p1_v_d, p1_own_q, p1_own_d;
   // return stage
   logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

   // winner / loser views of the two request channels
   logic          a_win, b_win, any_win;
   logic          w_is_b, w_we;
   logic [AW-1:0] w_addr, l_addr;
   logic [DW-1:0] w_wdata;
   logic          l_req, l_we, l_ok;

   // Arbitration and macro-pin generation; everything forced idle in reset
   always_comb begin
      a_win          = 1'b0;
      b_win          = 1'b0;
      any_win        = 1'b0;
      w_is_b         = 1'b0;
      w_we           = 1'b0;
      w_addr         = '0;
      w_wdata        = '0;
      l_req          = 1'b0;
      l_we           = 1'b0;
      l_addr         = '0;
      l_ok           = 1'b0;
      prio_d         = prio_q;
      p0_v_d         = 1'b0;
      p0_own_d       = 1'b0;
      p1_v_d         = 1'b0;
      p1_own_d       = 1'b0;
      bus.a_gnt      = 1'b0;
      bus.b_gnt      = 1'b0;
      bus.csb0       = 1'b1;
      bus.web0       = 1'b1;
      bus.addr0      = '0;
      bus.din0       = '0;
      bus.csb1       = 1'b1;
      bus.addr1      = '0;

      a_win   = bus.a_req && (!bus.b_req || !prio_q);
      b_win   = bus.b_req && !a_win;
      any_win = rst_n && (a_win || b_win);

      if (any_win) begin
         w_is_b  = b_win;
         w_we    = b_win ? bus.b_we    : bus.a_we;
         w_addr  = b_win ? bus.b_addr  : bus.a_addr;
         w_wdata = b_win ? bus.b_wdata : bus.a_wdata;
         l_req   = b_win ? bus.a_req   : bus.b_req;
         l_we    = b_win ? bus.a_we    : bus.b_we;
         l_addr  = b_win ? bus.a_addr  : bus.b_addr;

         // loser read is deferred when the winner writes the same word
         l_ok = l_req && !l_we && !(w_we && (w_addr == l_addr));

         bus.csb0  = 1'b0;
         bus.web0  = !w_we;
         bus.addr0 = w_addr;
         bus.din0  = w_wdata;
         p0_v_d    = !w_we;
         p0_own_d  = w_is_b;

         if (l_ok) begin
            bus.csb1 = 1'b0;
            bus.addr1 = l_addr;
            p1_v_d   = 1'b1;
            p1_own_d = !w_is_b;
         end

         bus.a_gnt = w_is_b ? l_ok : 1'b1;
         bus.b_gnt = w_is_b ? 1'b1 : l_ok;

         // a denied loser becomes preferred for the next cycle
         if (l_req && !l_ok) begin
            prio_d = !w_is_b;
         end
      end
   end

   // Read return: route each port's dout to the owner recorded at grant
   always_comb begin
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      if (p0_v_q) begin
         if (p0_own_q) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = bus.dout0;
         end else begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = bus.dout0;
         end
      end
      if (p1_v_q) begin
         if (p1_own_q) begin
            b_rvalid_d = 1'b1;
            b_rdata_d  = bus.dout1;
         end else begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = bus.dout1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= 1'b0;
         p0_v_q     <= 1'b0;
         p0_own_q   <= 1'b0;
         p1_v_q     <= 1'b0;
         p1_own_q   <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         prio_q     <= prio_d;
         p0_v_q     <= p0_v_d;
         p0_own_q   <= p0_own_d;
         p1_v_q     <= p1_v_d;
         p1_own_q   <= p1_own_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_rw_arbiter
// Purpose : directed self-checking bench for sram_rw_arbiter with a
//           behavioural 1RW+1R macro (inputs captured at posedge, array
//           written / dout updated at the following negedge).
// ---------------------------------------------------------------------------
module tb_sram_rw_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   sram_rw_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sram_rw_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // power-up contents of never-written words
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return DW'(32'(a) * 7 + 3);
   endfunction

   // contents after all writes issued before the streaming phase
   function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
      case (a)
         10'h010: return 8'h3C;
         10'h100: return 8'hAA;
         10'h101: return 8'hBB;
         10'h200: return 8'h55;
         default: return init_val(a);
      endcase
   endfunction

   // macro model
   logic [DW-1:0] mem [DEPTH];
   logic          wr  [DEPTH] = '{default: 1'b0};
   logic          m0_cs = 1'b0, m0_we = 1'b0, m1_cs = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_din = '0;

   always @(posedge clk) begin
      m0_cs   <= (bus.csb0 === 1'b0);
      m0_we   <= (bus.web0 === 1'b0);
      m0_addr <= bus.addr0;
      m0_din  <= bus.din0;
      m1_cs   <= (bus.csb1 === 1'b0);
      m1_addr <= bus.addr1;
   end

   always @(negedge clk) begin
      if (m0_cs && m0_we) begin
         mem[m0_addr] <= m0_din;
         wr[m0_addr]  <= 1'b1;
      end
      if (m0_cs && !m0_we) bus.dout0 <= wr[m0_addr] ? mem[m0_addr] : init_val(m0_addr);
      if (m1_cs)           bus.dout1 <= wr[m1_addr] ? mem[m1_addr] : init_val(m1_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
   endtask

   initial begin
      bus.dout0 = '0;
      bus.dout1 = '0;

      // reset held with both requesters active
      drive_a(1'b1, 1'b0, 10'h005, 8'h00);
      drive_b(1'b1, 1'b1, 10'h007, 8'h11);
      repeat (3) @(posedge clk);
      #4;
      check("rst_csb0",     32'(bus.csb0),     32'd1);
      check("rst_csb1",     32'(bus.csb1),     32'd1);
      check("rst_web0",     32'(bus.web0),     32'd1);
      check("rst_a_gnt",    32'(bus.a_gnt),    32'd0);
      check("rst_b_gnt",    32'(bus.b_gnt),    32'd0);
      check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
      check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
      check("rst_a_rdata",  32'(bus.a_rdata),  32'd0);
      check("rst_b_rdata",  32'(bus.b_rdata),  32'd0);

      // release, A reads 0x005
      next(); rst_n = 1'b1; drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      check("rel_a_gnt", 32'(bus.a_gnt), 32'd1);
      check("rel_b_gnt", 32'(bus.b_gnt), 32'd0);
      check("rel_csb0",  32'(bus.csb0),  32'd0);
      check("rel_web0",  32'(bus.web0),  32'd1);
      check("rel_addr0", 32'(bus.addr0), 32'h005);
      check("rel_csb1",  32'(bus.csb1),  32'd1);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); settle();
      check("rel_rvalid_n1", 32'(bus.a_rvalid), 32'd0);
      next(); settle();
      check("rel_rvalid_n2", 32'(bus.a_rvalid), 32'd1);
      check("rel_rdata_n2",  32'(bus.a_rdata),  32'(init_val(10'h005)));
      check("rel_b_rvalid",  32'(bus.b_rvalid), 32'd0);
      next(); settle();
      check("rel_rvalid_n3", 32'(bus.a_rvalid), 32'd0);
      check("rel_rdata_hold", 32'(bus.a_rdata), 32'(init_val(10'h005)));

      // parallel reads after a write
      next(); drive_a(1'b1, 1'b1, 10'h010, 8'h3C); settle();
      check("par_wr_gnt",  32'(bus.a_gnt), 32'd1);
      check("par_wr_web0", 32'(bus.web0),  32'd0);
      check("par_wr_din0", 32'(bus.din0),  32'h3C);
      next(); drive_a(1'b1, 1'b0, 10'h010, 8'h00); drive_b(1'b1, 1'b0, 10'h011, 8'h00); settle();
      check("par_a_gnt", 32'(bus.a_gnt), 32'd1);
      check("par_b_gnt", 32'(bus.b_gnt), 32'd1);
      check("par_addr0", 32'(bus.addr0), 32'h010);
      check("par_csb1",  32'(bus.csb1),  32'd0);
      check("par_addr1", 32'(bus.addr1), 32'h011);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      check("par_rvalid_early", 32'(bus.a_rvalid), 32'd0);
      next(); settle();
      check("par_a_rvalid", 32'(bus.a_rvalid), 32'd1);
      check("par_b_rvalid", 32'(bus.b_rvalid), 32'd1);
      check("par_a_rdata",  32'(bus.a_rdata),  32'h3C);
      check("par_b_rdata",  32'(bus.b_rdata),  32'(init_val(10'h011)));

      // write contention: grants alternate A,B,A,B
      for (int i = 0; i < 4; i++) begin
         next();
         if (i == 0) begin
            drive_a(1'b1, 1'b1, 10'h100, 8'hAA);
            drive_b(1'b1, 1'b1, 10'h101, 8'hBB);
         end
         settle();
         check("wc_a_gnt", 32'(bus.a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("wc_b_gnt", 32'(bus.b_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
         check("wc_din0",  32'(bus.din0),  (i % 2 == 0) ? 32'hAA : 32'hBB);
         check("wc_csb1",  32'(bus.csb1),  32'd1);
      end
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      check("idle_csb0",  32'(bus.csb0),  32'd1);
      check("idle_web0",  32'(bus.web0),  32'd1);
      check("idle_addr0", 32'(bus.addr0), 32'd0);
      check("idle_din0",  32'(bus.din0),  32'd0);
      next(); drive_a(1'b1, 1'b0, 10'h100, 8'h00); drive_b(1'b1, 1'b0, 10'h101, 8'h00); settle();
      check("wc_rd_a_gnt", 32'(bus.a_gnt), 32'd1);
      check("wc_rd_b_gnt", 32'(bus.b_gnt), 32'd1);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      next(); settle();
      check("wc_rd_a_rvalid", 32'(bus.a_rvalid), 32'd1);
      check("wc_rd_b_rvalid", 32'(bus.b_rvalid), 32'd1);
      check("wc_rd_a_rdata",  32'(bus.a_rdata),  32'hAA);
      check("wc_rd_b_rdata",  32'(bus.b_rdata),  32'hBB);

      // same-address hazard, prio = A
      next(); drive_a(1'b1, 1'b1, 10'h200, 8'h55); drive_b(1'b1, 1'b0, 10'h200, 8'h00); settle();
      check("hz_a_gnt", 32'(bus.a_gnt), 32'd1);
      check("hz_b_gnt", 32'(bus.b_gnt), 32'd0);
      check("hz_csb1",  32'(bus.csb1),  32'd1);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); settle();
      check("hz_b_gnt_next", 32'(bus.b_gnt), 32'd1);
      check("hz_csb0",       32'(bus.csb0),  32'd0);
      check("hz_web0",       32'(bus.web0),  32'd1);
      check("hz_addr0",      32'(bus.addr0), 32'h200);
      next(); drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      next(); settle();
      check("hz_b_rvalid", 32'(bus.b_rvalid), 32'd1);
      check("hz_b_rdata",  32'(bus.b_rdata),  32'h55);

      // mid-read reset (prio is B-preferred going in)
      next(); drive_a(1'b1, 1'b0, 10'h020, 8'h00); settle();
      check("mr_a_gnt", 32'(bus.a_gnt), 32'd1);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); rst_n = 1'b0; settle();
      check("mr_csb0",   32'(bus.csb0),     32'd1);
      check("mr_rvalid", 32'(bus.a_rvalid), 32'd0);
      next(); rst_n = 1'b1; settle();
      check("mr_rvalid_rel", 32'(bus.a_rvalid), 32'd0);
      check("mr_rdata_rel",  32'(bus.a_rdata),  32'd0);
      next(); settle();
      check("mr_rvalid_late", 32'(bus.a_rvalid), 32'd0);
      // prio back to A: A takes port 0, B rides port 1
      next(); drive_a(1'b1, 1'b0, 10'h030, 8'h00); drive_b(1'b1, 1'b0, 10'h031, 8'h00); settle();
      check("mr_prio_addr0", 32'(bus.addr0), 32'h030);
      check("mr_prio_addr1", 32'(bus.addr1), 32'h031);
      next(); drive_a(1'b0, 1'b0, 10'h000, 8'h00); drive_b(1'b0, 1'b0, 10'h000, 8'h00); settle();
      next(); settle();
      check("mr_prio_a_rdata", 32'(bus.a_rdata), 32'(init_val(10'h030)));
      check("mr_prio_b_rdata", 32'(bus.b_rdata), 32'(init_val(10'h031)));
      next(); settle();

      // streaming reads 0x000..0x3FF then wrap to 0x000
      for (int k = 0; k <= 1026; k++) begin
         next();
         if (k <= 1024) drive_a(1'b1, 1'b0, AW'(k), 8'h00);
         else           drive_a(1'b0, 1'b0, 10'h000, 8'h00);
         settle();
         if (k <= 1024) check("st_gnt", 32'(bus.a_gnt), 32'd1);
         if (k >= 2) begin
            check("st_rvalid", 32'(bus.a_rvalid), 32'd1);
            check("st_rdata",  32'(bus.a_rdata),  32'(exp_mem(AW'(k - 2))));
         end else begin
            check("st_rvalid_pre", 32'(bus.a_rvalid), 32'd0);
         end
      end
      next(); settle();
      check("st_rvalid_end", 32'(bus.a_rvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester arbiter and sequencer for the 1RW+1R 8x1024 OpenRAM SRAM macro. It shares the macro between requester A and requester B: port 0 (RW) goes to the round-robin winner, and port 1 (R) serves the loser's read in the same cycle when that is hazard-free. It generates the macro's active-low chip-select and write-enable. It returns read data on a fixed two-cycle latency, tagged per requester.

## Interface
- DATA_WIDTH, 8: data word width; must match the macro.
- ADDR_WIDTH, 10: word address width; must match the macro.

- clk  in  1  single clock; also drives macro clk0 and clk1 externally.
- rst_n  in  1  asynchronous active-low reset.
- a_req / b_req  in  1  request valid; held with its fields until granted.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_WIDTH  word address.
- a_wdata / b_wdata  in  DATA_WIDTH  write data.
- a_gnt / b_gnt  out  1  combinational; request accepted this cycle.
- a_rvalid / b_rvalid  out  1  registered; read data valid (one-cycle pulse).
- a_rdata / b_rdata  out  DATA_WIDTH  registered read data; holds between pulses.
- csb0, web0  out  1  macro port 0 chip select and write enable, active-low, combinational.
- addr0  out  ADDR_WIDTH  macro port 0 address, combinational.
- din0  out  DATA_WIDTH  macro port 0 write data, combinational.
- dout0  in  DATA_WIDTH  macro port 0 read data.
- csb1  out  1  macro port 1 chip select, active-low, combinational.
- addr1  out  ADDR_WIDTH  macro port 1 address, combinational.
- dout1  in  DATA_WIDTH  macro port 1 read data.

## Operation
- **Priority state.** prio is a 1-bit register: 0 = A preferred, 1 = B preferred. Reset value is 0.
- **Winner W.** W is the only requester, or the preferred one when both request.
- W drives port 0: csb0=0, web0=~W.we, addr0=W.addr, din0=W.wdata. W's gnt=1.
- **Loser L.** L is the other requester, if it is requesting.
  - L is granted on port 1 (csb1=0, addr1=L.addr) iff L.we=0 and NOT (W.we=1 and W.addr==L.addr).
  - Otherwise L gnt=0 and L must hold its request.
- **Idle ports.** With no requests, csb0=csb1=1 and web0=1. With no port-1 use, csb1=1. Unused address and data outputs drive 0.
- **prio update.** At a clock edge where L was requesting and denied, prio := L. Otherwise prio is unchanged. A denied requester therefore wins the next cycle.
- **Writes** complete at grant; no acknowledge beyond gnt.
- **Read tracking.** A 2-stage tag pipeline per macro port records (valid, owner).
  - Stage 1 is loaded at grant.
  - Stage 2 captures the macro dout at the following edge into the owner's rdata and pulses the owner's rvalid.
  - Both ports can return in the same cycle to different owners. The same owner never gets two returns in one cycle, because one requester issues at most one request per cycle.
- **Reset.**
  - While rst_n=0: csb0=csb1=web0=1, gnt=0, rvalid=0, rdata=0, prio=0, tag pipelines cleared.
  - Reset asserted mid-read discards the in-flight read; no rvalid follows deassertion.

## Timing
- Read latency: request granted in cycle N → rvalid/rdata in cycle N+2.
  - The macro captures its inputs at the edge ending cycle N.
  - dout is valid after the negedge in N+1.
  - The arbiter registers dout at the edge ending N+1, before the macro's post-edge hold window expires.
- Back-to-back: one grant per requester per cycle; full throughput, pipelined reads.
- Write-then-read to the same address in consecutive cycles returns the new data: the write lands at the negedge of cycle N+1 and the read is captured at the edge ending N+1.
- Same-cycle write (port 0) plus read (port 1) to the same address is never issued; the read is deferred one cycle.
- gnt and all macro inputs depend combinationally on req/we/addr/wdata and prio. There is no combinational path from dout to any output.

## Test plan
- **Reset.** Hold rst_n=0 with both requesters active. Expect csb0=csb1=1, gnt=0, rvalid=0. Release rst_n, A read addr 0x005 → a_gnt that cycle, a_rvalid two cycles later with mem[0x005].
- **Parallel reads.** A writes 0x3C to 0x010, then A reads 0x010 and B reads 0x011 in the same cycle.
  - Expect both granted, A on port 0 and B on port 1.
  - Expect both rvalid in the same cycle: a_rdata=0x3C, b_rdata=mem[0x011].
- **Write contention.** A and B both write continuously (A 0xAA→0x100, B 0xBB→0x101). Expect grants alternate A,B,A,B; after both complete, reads return 0xAA and 0xBB.
- **Same-address hazard.** With prio=A, A writes 0x55 to 0x200 while B reads 0x200.
  - Expect b_gnt=0 that cycle and b_gnt=1 the next.
  - Expect b_rdata=0x55.
- **Mid-read reset.** A read granted, rst_n pulsed low in the next cycle. Expect no a_rvalid, a_rdata=0, prio=0 after release.
- **Streaming.** A reads 0x000..0x3FF back-to-back with the address wrapping to 0x000. Expect 1024 consecutive rvalid pulses, data in order, then the wrapped word.
